ps2_rx_ctrl: RTL and testbench
==============================

// Module: ps2_rx_ctrl
// PURPOSE
//  Parametrised PS/2 device-to-host receiver with deep byte FIFO, internal frame timeout,
//  clock glitch filter and per-cause error flags. Sits between the PS/2 pins (keyboard/mouse)
//  and the game-logic consumer; replaces the fixed 8-deep, external-watchdog receiver.
// PARAMETERS
//  DEPTH_LOG2      3       FIFO depth = 2**DEPTH_LOG2 bytes (1..6)
//  SYNC_STAGES     3       synchroniser flops on ps2c/ps2d (>=2)
//  FILTER_LEN      4       consecutive equal synced samples needed to change filtered ps2c (>=1)
//  TIMEOUT_CYCLES  50000   clk cycles with no falling edge mid-frame before abort (~500us @100MHz)
// PORTS
//  clk            in   1             system clock
//  reset          in   1             synchronous, active-high reset
//  ps2c           in   1             raw PS/2 clock pin (async)
//  ps2d           in   1             raw PS/2 data pin (async)
//  fifo_rd        in   1             pop head byte; ignored when fifo_empty
//  err_clr        in   1             clears parity_err/frame_err/timeout_err
//  fifo_data      out  8             head byte (combinational from rptr); undefined when empty
//  fifo_empty     out  1             count==0
//  fifo_full      out  1             count==2**DEPTH_LOG2
//  fifo_count     out  DEPTH_LOG2+1  bytes held
//  fifo_overflow  out  1             sticky: frame dropped because FIFO full
//  parity_err     out  1             sticky: frame had even parity
//  frame_err      out  1             sticky: start bit 1 or stop bit 0
//  timeout_err    out  1             sticky: frame aborted by timeout
// BEHAVIOUR
//  - Reset: all outputs 0 except fifo_empty=1; FSM IDLE; ptrs/count 0; filter state 1 (idle high).
//  - Sync: ps2c, ps2d through SYNC_STAGES flops. Filter: filtered ps2c changes only after
//    FILTER_LEN consecutive synced samples differ from it. sample = 1-cycle pulse on filtered 1->0.
//  - FSM: IDLE -> (sample) RECV; RECV shifts synced ps2d LSB-first into 11-bit frame
//    {stop,par,d[7:0],start}; after 11th sample -> CHECK (one cycle) -> IDLE.
//  - CHECK: start==0 && stop==1 && ^{par,d}==1 -> write d. Else set frame_err and/or parity_err; no write.
//  - Timeout: cycle counter cleared on each sample, runs in RECV only; at TIMEOUT_CYCLES-1 -> IDLE,
//    timeout_err=1, partial frame discarded. Counter width $clog2(TIMEOUT_CYCLES).
//  - Latency: fifo_empty falls 2 cycles after the stop-bit sample pulse (CHECK, then registered write).
//  - Write when full: byte dropped, fifo_overflow=1, contents/ptrs unchanged (no overwrite).
//  - Simultaneous write+rd when full: read frees a slot; write accepted; count unchanged; no overflow.
//  - Simultaneous write+rd when empty: read ignored, write accepted, count=1.
//  - fifo_rd && !fifo_empty: rptr++, fifo_overflow cleared (unless set same cycle: set wins).
//  - err_clr clears error flags; an error raised in the same cycle wins.
//  - Pointers wrap modulo 2**DEPTH_LOG2; count is separate so full/empty unambiguous.
//  - Reset mid-frame: frame discarded, FIFO emptied, next frame received normally.
// CONFIGURATION
//  PS2_RX_ERR_STATS_EN defined: adds outputs err_cnt_parity/err_cnt_frame/err_cnt_timeout
//    [7:0], saturating at 255, each +1 per error event, cleared by reset only.
//  Undefined: counters and ports absent; sticky flags unchanged.
// STRUCTURE
//  - ps2_pkg: state enum {IDLE,RECV,CHECK}, PS2_FRAME_BITS=11, PS2_DATA_BITS=8.
//  - Sub-module ps2_byte_fifo (DEPTH_LOG2): storage, ptrs, count, full/empty, overflow;
//    reused later by the host-to-device transmit path.
//  - Top holds sync, glitch filter, FSM, timeout counter, error flags.
// TESTING
//  - Frame 0x1C (start 0, data LSB-first, par 0, stop 1), 30us bit period -> fifo_count=1,
//    fifo_data=0x1C, no error flags; fifo_rd -> fifo_empty=1.
//  - Frame 0x1C with par=1 -> parity_err=1, fifo_empty stays 1; err_clr -> parity_err=0.
//  - Stop 5 bits into a frame, idle TIMEOUT_CYCLES -> timeout_err=1, FSM IDLE; next frame
//    0xF0 received cleanly.
//  - 1-cycle low glitches on ps2c (< FILTER_LEN) during idle and mid-frame -> no extra samples,
//    bytes received intact.
//  - DEPTH_LOG2=2: send 5 bytes 0x01..0x05, no reads -> fifo_full=1, count=4, overflow=1,
//    reads return 0x01..0x04; rd on last write cycle at full -> no overflow.
//  - Assert reset at bit 6 of a frame -> all outputs at reset values; following 0x5A received.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive (and future transmit) path.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   ps2_state_t    receiver FSM states {IDLE, RECV, CHECK}
//   ps2_chk_t      per-cause result of inspecting a completed 11-bit frame
//   PS2_FRAME_BITS bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_DATA_BITS  payload bits per frame
//   ps2_check()    classifies a frame laid out as {stop, par, d[7:0], start}
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } ps2_state_t;

  typedef struct packed {
    logic frame_bad;   // start bit 1 or stop bit 0
    logic parity_bad;  // data plus parity bit has an even number of ones
  } ps2_chk_t;

  // PS/2 uses odd parity over the data byte and the parity bit together.
  function automatic ps2_chk_t ps2_check(input logic [PS2_FRAME_BITS-1:0] f);
    ps2_chk_t r;
    r.frame_bad  = f[0] | ~f[PS2_FRAME_BITS-1];
    r.parity_bad = ~(^f[PS2_FRAME_BITS-2:1]);
    return r;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO with explicit occupancy count and sticky overflow flag.
// Latency: a written byte is visible on rd_data / count one clock after wr_en.
// Backpressure: none upstream; a write into a full FIFO (with no read in the same cycle) is dropped.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   wr_en, wr_data  push request and byte
//   rd_en           pop head byte (ignored when empty)
//   rd_data         head byte, combinational from the read pointer
//   empty, full     occupancy flags derived from count
//   count           bytes held, 0 .. 2**DEPTH_LOG2
//   overflow        sticky: a write was dropped; cleared by a successful pop
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [PS2_DATA_BITS-1:0] wr_data,
  input  logic                     rd_en,
  output logic [PS2_DATA_BITS-1:0] rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [DEPTH_LOG2:0]      count,
  output logic                     overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [PS2_DATA_BITS-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]    wptr;
  logic [DEPTH_LOG2-1:0]    rptr;
  logic                     rd_ok;
  logic                     wr_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign rd_data = mem[rptr];

  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  // A pop at empty is ignored, so a simultaneous write simply lands.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      // Cleared so the head byte reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      // A drop in the same cycle as a pop keeps the flag set.
      if (wr_en && !wr_ok) begin
        overflow <= 1'b1;
      end else if (rd_ok) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: pin sync, clock glitch filter, frame FSM, timeout, byte FIFO.
// Latency: fifo_empty falls 2 clk after the stop-bit sample (CHECK cycle, then registered write).
// Backpressure: none toward the device; frames arriving while the FIFO is full are dropped.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   ps2c, ps2d      raw asynchronous PS/2 clock and data pins
//   fifo_rd         pop head byte (ignored when empty)
//   err_clr         clears parity_err / frame_err / timeout_err
//   fifo_data       head byte; fifo_empty / fifo_full / fifo_count occupancy
//   fifo_overflow   sticky: a good frame was dropped because the FIFO was full
//   parity_err      sticky: frame had even parity
//   frame_err       sticky: start bit 1 or stop bit 0
//   timeout_err     sticky: frame abandoned after TIMEOUT_CYCLES without a clock edge
//
// Optional build macro PS2_RX_ERR_STATS_EN adds saturating 8-bit per-cause error event
// counters err_cnt_parity / err_cnt_frame / err_cnt_timeout, cleared only by reset.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2     = 3,
  parameter int SYNC_STAGES    = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2c,
  input  logic                     ps2d,
  input  logic                     fifo_rd,
  input  logic                     err_clr,
  output logic [PS2_DATA_BITS-1:0] fifo_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [DEPTH_LOG2:0]      fifo_count,
  output logic                     fifo_overflow,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     timeout_err
`ifdef PS2_RX_ERR_STATS_EN
  ,
  output logic [7:0]               err_cnt_parity,
  output logic [7:0]               err_cnt_frame,
  output logic [7:0]               err_cnt_timeout
`endif
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT_IDX = 4'(PS2_FRAME_BITS - 1);

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic                   c_s;
  logic                   d_s;

  // Reset to 1 so the idle-high bus does not look like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync <= '1;
      d_sync <= '1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], ps2c};
      d_sync <= {d_sync[SYNC_STAGES-2:0], ps2d};
    end
  end

  assign c_s = c_sync[SYNC_STAGES-1];
  assign d_s = d_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------- glitch filter
  logic           filt_c;
  logic [FCW-1:0] filt_cnt;
  logic           differ;
  logic           filt_flip;
  logic           sample;

  // filt_cnt counts consecutive synced samples that disagree with filt_c;
  // the FILTER_LEN-th disagreeing sample flips the filtered clock.
  assign differ    = (c_s != filt_c);
  assign filt_flip = differ && (filt_cnt == FILT_LAST);
  // Pulse in the cycle the filtered clock goes 1->0; data is taken from d_s here.
  assign sample    = filt_flip && filt_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_c   <= 1'b1;
      filt_cnt <= '0;
    end else if (!differ) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_c   <= c_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- frame FSM
  ps2_state_t                state;
  ps2_state_t                state_nxt;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic [3:0]                bit_cnt;
  logic [TW-1:0]             tmo_cnt;
  logic                      tmo_hit;
  logic                      last_bit;
  ps2_chk_t                  chk;
  logic                      fifo_wr;
  logic                      set_par;
  logic                      set_frame;
  logic                      set_tmo;

  assign chk      = ps2_check(frame);
  assign last_bit = sample && (bit_cnt == LAST_BIT_IDX);
  // A sample arriving on the last allowed cycle still counts as progress.
  assign tmo_hit  = (state == RECV) && !sample && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_wr   = 1'b0;
    set_par   = 1'b0;
    set_frame = 1'b0;
    set_tmo   = 1'b0;
    case (state)
      IDLE: begin
        // The falling edge that leaves IDLE carries the start bit.
        if (sample) begin
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (last_bit) begin
          state_nxt = CHECK;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          set_tmo   = 1'b1;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (!chk.frame_bad && !chk.parity_bad) begin
          fifo_wr = 1'b1;
        end else begin
          set_frame = chk.frame_bad;
          set_par   = chk.parity_bad;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame shifts right so the first bit received (start) ends up in frame[0]
  // and the stop bit in frame[10] after eleven samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame   <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (sample && (state == IDLE || state == RECV)) begin
        frame   <= {d_s, frame[PS2_FRAME_BITS-1:1]};
        bit_cnt <= (state == IDLE) ? 4'd1 : bit_cnt + 4'd1;
      end
      if (state == RECV && !sample && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- error flags
  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      parity_err  <= set_par   | (parity_err  & ~err_clr);
      frame_err   <= set_frame | (frame_err   & ~err_clr);
      timeout_err <= set_tmo   | (timeout_err & ~err_clr);
    end
  end

`ifdef PS2_RX_ERR_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_parity  <= '0;
      err_cnt_frame   <= '0;
      err_cnt_timeout <= '0;
    end else begin
      if (set_par && err_cnt_parity != 8'hFF) begin
        err_cnt_parity <= err_cnt_parity + 8'd1;
      end
      if (set_frame && err_cnt_frame != 8'hFF) begin
        err_cnt_frame <= err_cnt_frame + 8'd1;
      end
      if (set_tmo && err_cnt_timeout != 8'hFF) begin
        err_cnt_timeout <= err_cnt_timeout + 8'd1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------- byte FIFO
  ps2_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (fifo_wr),
    .wr_data  (frame[PS2_DATA_BITS:1]),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Testbench for ps2_rx_ctrl: directed frame table, glitch/timeout/depth/reset sequences,
// then randomized frames checked against a queue-based reference model.
// Inputs change on the falling clk edge; outputs are sampled on the falling edge.
module tb_ps2_rx_ctrl;

  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  localparam int TMO   = 200;
  localparam int H     = 16;   // PS/2 half bit period in clk cycles
  localparam int GL    = 3;    // glitch length: one short of FILTER_LEN

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ps2c, ps2d, fifo_rd, err_clr;
  logic [7:0] fifo_data;
  logic       fifo_empty, fifo_full;
  logic [DL2:0] fifo_count;
  logic       fifo_overflow, parity_err, frame_err, timeout_err;
`ifdef PS2_RX_ERR_STATS_EN
  logic [7:0] err_cnt_parity, err_cnt_frame, err_cnt_timeout;
`endif

  ps2_rx_ctrl #(
    .DEPTH_LOG2(DL2), .SYNC_STAGES(3), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .fifo_rd(fifo_rd), .err_clr(err_clr),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .fifo_overflow(fifo_overflow),
    .parity_err(parity_err), .frame_err(frame_err), .timeout_err(timeout_err)
`ifdef PS2_RX_ERR_STATS_EN
    , .err_cnt_parity(err_cnt_parity), .err_cnt_frame(err_cnt_frame),
    .err_cnt_timeout(err_cnt_timeout)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: byte queue plus sticky flags and error event counts.
  logic [7:0] q[$];
  bit m_ovf, m_par, m_frm, m_tmo;
  int c_par, c_frm, c_tmo;

  typedef struct {
    logic [7:0] d;
    bit pflip;
    bit st;
    bit sp;
    int exp_cnt;
    bit exp_par;
    bit exp_frm;
  } vec_t;
  vec_t tbl[7];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit pflip,
                                     input bit st, input bit sp);
    return {sp, (~^d) ^ pflip, d, st};
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void model_read();
    if (q.size() > 0) begin
      void'(q.pop_front());
      m_ovf = 1'b0;
    end
  endfunction

  function automatic void model_frame(input logic [10:0] b, input int nbits);
    bit fbad, pbad;
    if (nbits < 11) begin
      m_tmo = 1'b1;
      c_tmo = sat(c_tmo + 1);
    end else begin
      fbad = (b[0] != 1'b0) || (b[10] != 1'b1);
      pbad = ($countones(b[9:1]) % 2) == 0;
      if (!fbad && !pbad) begin
        if (q.size() < DEPTH) q.push_back(b[8:1]);
        else m_ovf = 1'b1;
      end else begin
        if (fbad) begin m_frm = 1'b1; c_frm = sat(c_frm + 1); end
        if (pbad) begin m_par = 1'b1; c_par = sat(c_par + 1); end
      end
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf = 0; m_par = 0; m_frm = 0; m_tmo = 0;
    c_par = 0; c_frm = 0; c_tmo = 0;
  endfunction

  // Drives nbits of a frame LSB first: data changes while the clock is high.
  // glitch: short low pulse in bit 4's high phase and high spike in bit 6's low phase.
  // rd_on_stop: pulses fifo_rd in the cycle the stop-bit byte is presented for writing.
  task automatic send(input logic [10:0] b, input int nbits, input bit glitch,
                      input bit rd_on_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2d = b[i];
      if (glitch && i == 4) begin
        tick(8); ps2c = 1'b0; tick(GL); ps2c = 1'b1; tick(H - 8 - GL);
      end else begin
        tick(H);
      end
      ps2c = 1'b0;
      if (rd_on_stop && i == 10) begin
        tick(7); fifo_rd = 1'b1; tick(1); fifo_rd = 1'b0; tick(H - 8);
      end else if (glitch && i == 6) begin
        tick(8); ps2c = 1'b1; tick(GL); ps2c = 1'b0; tick(H - 8 - GL);
      end else begin
        tick(H);
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    tick(H);
    if (rd_on_stop) model_read();
    model_frame(b, nbits);
  endtask

  task automatic do_read();
    fifo_rd = 1'b1; tick(1); fifo_rd = 1'b0; tick(1);
    model_read();
  endtask

  task automatic do_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    m_par = 0; m_frm = 0; m_tmo = 0;
  endtask

  task automatic check_state(input string nm);
    chk({nm, ".count"}, 32'(fifo_count), q.size());
    chk({nm, ".empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    chk({nm, ".full"},  32'(fifo_full),  32'(q.size() == DEPTH));
    chk({nm, ".ovf"},   32'(fifo_overflow), 32'(m_ovf));
    chk({nm, ".par"},   32'(parity_err),  32'(m_par));
    chk({nm, ".frm"},   32'(frame_err),   32'(m_frm));
    chk({nm, ".tmo"},   32'(timeout_err), 32'(m_tmo));
    if (q.size() > 0) chk({nm, ".data"}, 32'(fifo_data), 32'(q[0]));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".data"},  32'(fifo_data), 0);
    chk({nm, ".empty"}, 32'(fifo_empty), 1);
    chk({nm, ".full"},  32'(fifo_full), 0);
    chk({nm, ".count"}, 32'(fifo_count), 0);
    chk({nm, ".ovf"},   32'(fifo_overflow), 0);
    chk({nm, ".par"},   32'(parity_err), 0);
    chk({nm, ".frm"},   32'(frame_err), 0);
    chk({nm, ".tmo"},   32'(timeout_err), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, test did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int r, nb, nr;
    bit pf, st, sp;

    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; fifo_rd = 1'b0; err_clr = 1'b0;
    model_reset();
    tick(5);
    chk_reset_vals("reset");
    reset = 1'b0;
    tick(5);

    // ---- directed frame table: {data, par flip, start, stop, exp count, exp par, exp frm}
    tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    tbl[1] = '{8'h1C, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    tbl[2] = '{8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    tbl[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      send(mk(tbl[i].d, tbl[i].pflip, tbl[i].st, tbl[i].sp), 11, 1'b0, 1'b0);
      chk($sformatf("tbl%0d.count", i), 32'(fifo_count), tbl[i].exp_cnt);
      chk($sformatf("tbl%0d.par", i), 32'(parity_err), 32'(tbl[i].exp_par));
      chk($sformatf("tbl%0d.frm", i), 32'(frame_err), 32'(tbl[i].exp_frm));
      chk($sformatf("tbl%0d.tmo", i), 32'(timeout_err), 0);
      if (tbl[i].exp_cnt != 0) chk($sformatf("tbl%0d.data", i), 32'(fifo_data), 32'(tbl[i].d));
      if (tbl[i].exp_par || tbl[i].exp_frm) begin
        do_clr();
        chk($sformatf("tbl%0d.clr", i), 32'({parity_err, frame_err}), 0);
      end
      if (tbl[i].exp_cnt != 0) begin
        do_read();
        chk($sformatf("tbl%0d.rd_empty", i), 32'(fifo_empty), 1);
      end
    end

    // ---- timeout: 5 bits then silence; then a clean frame
    send(mk(8'h55, 1'b0, 1'b0, 1'b1), 5, 1'b0, 1'b0);
    chk("tmo.early", 32'(timeout_err), 0);
    tick(TMO + 20);
    check_state("tmo.fired");
    send(mk(8'hF0, 1'b0, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    check_state("tmo.next");
    do_clr();
    do_read();
    check_state("tmo.clean");

    // ---- glitches shorter than the filter, idle and mid-frame
    ps2c = 1'b0; tick(GL); ps2c = 1'b1; tick(20);
    check_state("glitch.idle");
    send(mk(8'h5A, 1'b0, 1'b0, 1'b1), 11, 1'b1, 1'b0);
    chk("glitch.data", 32'(fifo_data), 32'h5A);
    tick(TMO + 20);
    check_state("glitch.frame");
    do_read();

    // ---- depth: 5 frames into a 4-deep FIFO, then drain
    for (int i = 1; i <= 5; i++) send(mk(8'(i), 1'b0, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    chk("depth.full", 32'(fifo_full), 1);
    chk("depth.count", 32'(fifo_count), 4);
    chk("depth.ovf", 32'(fifo_overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("depth.rd%0d", i), 32'(fifo_data), i);
      do_read();
      if (i == 1) chk("depth.ovf_clr", 32'(fifo_overflow), 0);
    end
    check_state("depth.drained");

    // ---- read in the same cycle as a write at full
    for (int i = 1; i <= 4; i++) send(mk(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    send(mk(8'h15, 1'b0, 1'b0, 1'b1), 11, 1'b0, 1'b1);
    chk("rdwr.count", 32'(fifo_count), 4);
    chk("rdwr.ovf", 32'(fifo_overflow), 0);
    chk("rdwr.head", 32'(fifo_data), 32'h12);
    for (int i = 0; i < 4; i++) begin
      check_state($sformatf("rdwr.drain%0d", i));
      do_read();
    end

    // ---- randomized frames against the model
    for (int k = 0; k < 30; k++) begin
      d  = 8'($urandom);
      r  = $urandom_range(0, 19);
      pf = (r <= 1);
      st = (r == 2);
      sp = (r != 3);
      nb = (r == 4) ? $urandom_range(2, 10) : 11;
      send(mk(d, pf, st, sp), nb, 1'b0, 1'b0);
      if (nb < 11) tick(TMO + 20);
      check_state($sformatf("rnd%0d.frame", k));
      nr = $urandom_range(0, 2);
      for (int j = 0; j < nr; j++) begin
        do_read();
        check_state($sformatf("rnd%0d.rd%0d", k, j));
      end
      if ($urandom_range(0, 3) == 0) begin
        do_clr();
        check_state($sformatf("rnd%0d.clr", k));
      end
    end

`ifdef PS2_RX_ERR_STATS_EN
    chk("stats.par", 32'(err_cnt_parity), c_par);
    chk("stats.frm", 32'(err_cnt_frame), c_frm);
    chk("stats.tmo", 32'(err_cnt_timeout), c_tmo);
`endif

    // ---- reset mid-frame with data and a flag pending
    send(mk(8'h33, 1'b0, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    send(mk(8'h44, 1'b1, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    send(mk(8'h77, 1'b0, 1'b0, 1'b1), 6, 1'b0, 1'b0);
    reset = 1'b1;
    tick(3);
    chk_reset_vals("midrst");
    reset = 1'b0;
    model_reset();
    tick(5);
    send(mk(8'h5A, 1'b0, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    check_state("midrst.next");
    chk("midrst.data", 32'(fifo_data), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
